// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, totals helpers and coordinate type.
// Pure declarations: no latency, no flow control.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register aligning a sync level with downstream pixel data.
// Latency DEPTH cycles (0 = wire); free-running, no backpressure.
module sync_delay #(
    parameter int DEPTH = 1
) (
    input  logic vga_clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused;
            assign unused = &{1'b0, vga_clk, reset, rst_val};
            assign q      = d;
        end else begin : g_pipe
            logic stage [DEPTH];

            // Reset loads every stage so a mid-frame reset flushes stale sync.
            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, active-video flag, line/frame pulses and delayed HS/VS.
// Coordinates/blank/pulses coherent each cycle; sync lags by PIPE_DLY; no backpressure.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = H_ACTIVE_DEF,
    parameter int   H_FP        = H_FP_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BP        = H_BP_DEF,
    parameter int   V_ACTIVE    = V_ACTIVE_DEF,
    parameter int   V_FP        = V_FP_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BP        = V_BP_DEF,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DLY    = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_start
);

    localparam coord_t H_LAST = coord_t'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam coord_t V_LAST = coord_t'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam coord_t H_VIS  = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS  = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t hc, vc, hc_nxt, vc_nxt;
    logic   h_wrap, v_wrap;
    logic   hs_raw, vs_raw;

    always_comb begin
        h_wrap = (hc == H_LAST);
        v_wrap = (vc == V_LAST);
        hc_nxt = h_wrap ? '0 : hc + 10'd1;
        vc_nxt = vc;
        if (h_wrap) vc_nxt = v_wrap ? '0 : vc + 10'd1;
    end

    // Flags are derived from the next counter values so they land in the
    // same cycle as the coordinates they describe.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            blank       <= 1'b1;
            hs_raw      <= ~SYNC_ACTIVE;
            vs_raw      <= ~SYNC_ACTIVE;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            blank       <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
            hs_raw      <= ((hc_nxt >= HS_BEG) && (hc_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_raw      <= ((vc_nxt >= VS_BEG) && (vc_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

    sync_delay #(.DEPTH(PIPE_DLY)) u_hs_dly (
        .vga_clk (vga_clk),
        .reset   (reset),
        .rst_val (~SYNC_ACTIVE),
        .d       (hs_raw),
        .q       (hs)
    );

    sync_delay #(.DEPTH(PIPE_DLY)) u_vs_dly (
        .vga_clk (vga_clk),
        .reset   (reset),
        .rst_val (~SYNC_ACTIVE),
        .d       (vs_raw),
        .q       (vs)
    );

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock: horizontal/vertical counters, the `DrawX`/`DrawY` pixel coordinates and active-video `blank` consumed by sprite/ROM renderers, and HS/VS sync pulses. Sync outputs are delayed by a programmable pipeline depth so they stay aligned with renderer RGB, which is registered one or more cycles after the coordinates. Sits at the top of the display path and drives every sprite module and the VGA pins.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths in lines
- `SYNC_ACTIVE`, 1'b0, asserted level of `hs`/`vs` (0 = negative polarity)
- `PIPE_DLY`, 1, cycles of delay applied to `hs`/`vs` (legal range 0..4)
- `vga_clk`  in  1  pixel clock; all state on posedge
- `reset`  in  1  asynchronous, active-high reset
- `DrawX`  out  10  current horizontal counter, 0..H_TOTAL-1
- `DrawY`  out  10  current vertical counter, 0..V_TOTAL-1
- `blank`  out  1  1 = active video (DrawX<H_ACTIVE and DrawY<V_ACTIVE), 0 = blanking
- `hs`  out  1  horizontal sync, delayed by PIPE_DLY
- `vs`  out  1  vertical sync, delayed by PIPE_DLY
- `frame_start`  out  1  one-cycle pulse on the first pixel of each frame after a wrap
- `line_start`  out  1  one-cycle pulse when DrawX wraps to 0 (every line, incl. blanking)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL similarly (525).
- Horizontal counter hc increments every cycle; at H_TOTAL-1 it wraps to 0 and vertical counter vc increments; vc wraps to 0 at V_TOTAL-1 when hc also wraps.
- `DrawX`=hc, `DrawY`=vc, driven directly from the counter registers.
- `blank`, raw sync and pulse flags are registered, computed from the next counter values, so all are coherent with `DrawX`/`DrawY` in the same cycle.
- Raw hs asserted when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751); raw vs when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491).
- `hs`/`vs` = raw sync passed through a PIPE_DLY-stage shift register; PIPE_DLY=0 means no extra delay.
- `frame_start`=1 exactly in the cycle hc=0,vc=0 reached by wrap; `line_start`=1 in every cycle hc=0 reached by wrap.
- Counter arithmetic is 10-bit unsigned; comparisons use localparams only, no multipliers or dividers.

## Timing
- Reset (async assert, any cycle): hc=vc=0, `DrawX`=`DrawY`=0, `blank`=1, `hs`=`vs`=~SYNC_ACTIVE (including all delay stages), `frame_start`=`line_start`=0.
- First posedge after reset deassert: `DrawX`=1; no `frame_start`/`line_start` for the post-reset (0,0).
- Reset mid-frame: all outputs return to reset values immediately; sync delay stages flush to inactive.
- Line period 800 cycles, frame period 420000 cycles; hs low for 96 cycles, vs low for 2 full lines (1600 cycles).
- `hs` edge lags the raw sync edge by exactly PIPE_DLY cycles; `DrawX`/`DrawY`/`blank` are never delayed.
- `frame_start` and `line_start` coincide on the frame wrap cycle.

## Structure
- Package `vga_timing_pkg`: default timing localparams, H_TOTAL/V_TOTAL functions, 10-bit coordinate typedef.
- Sub-module `sync_delay` (parameterised depth, reset value input) instantiated twice, for hs and vs.

## Test plan
- Reset then 800 cycles -> DrawX runs 0..799, wraps to 0 with `line_start`=1, DrawY=1; blank 1 for DrawX 0..639 then 0.
- PIPE_DLY=1: hc=656 -> `hs` falls at cycle hc=657, rises at hc=753; 96-cycle low width.
- Full frame (420000 cycles) -> `vs` low for DrawY 490..491 (shifted 1 cycle); `frame_start` single pulse at (0,0); blank=0 for all DrawY>=480.
- Assert reset at DrawX=700, DrawY=300 -> same-cycle outputs 0,0, blank=1, hs=vs=1, pulses 0; resume from 1 after release.
- PIPE_DLY=0 and PIPE_DLY=3 -> hs edges at hc=656 and hc=659 respectively; DrawX timing unchanged.
- SYNC_ACTIVE=1 -> hs/vs idle 0, pulse 1 with identical widths; reset value 0.
